// File: rtl/nexys4_io_if_v2_if.sv
// PicoBlaze port bus between the KCPSM6 and the Nexys4 I/O register block.
// No flow control: strobes are single-cycle and reads return one clock after PortID.
interface nexys4_io_if_v2_if;
  logic [7:0] PortID;
  logic [7:0] DataIn;
  logic [7:0] DataOut;
  logic       WriteStrobe;
  logic       kWriteStrobe;
  logic       ReadStrobe;
  logic       Interrupt;
  logic       InterruptAck;

  modport master (
    output PortID, DataIn, WriteStrobe, kWriteStrobe, ReadStrobe, InterruptAck,
    input  DataOut, Interrupt
  );

  modport slave (
    input  PortID, DataIn, WriteStrobe, kWriteStrobe, ReadStrobe, InterruptAck,
    output DataOut, Interrupt
  );
endinterface

// File: rtl/nexys4_io_if_v2.sv
// PicoBlaze I/O decode for Nexys4 board I/O, Rojobot registers and an interrupt controller.
// Writes land on the strobe edge; DataOut is registered one clock behind PortID; no backpressure.
module nexys4_io_if_v2 #(
  parameter int         N_DIG    = 8,
  parameter int         LED_W    = 16,
  parameter int         SW_W     = 16,
  parameter int         BTN_W    = 5,
  parameter int         N_BOT    = 6,
  parameter int         N_IRQ    = 4,
  parameter logic [7:0] IRQ_EDGE = 8'hFF
) (
  input  logic                 clk,
  input  logic                 rst,
  nexys4_io_if_v2_if.slave     pb,
  output logic [7:0]           MotCtl,
  input  logic [8*N_BOT-1:0]   BotRegs,
  input  logic [N_IRQ-1:0]     IrqSrc,
  output logic [5*N_DIG-1:0]   Dig,
  output logic [N_DIG-1:0]     DP,
  output logic [LED_W-1:0]     LED,
  input  logic [BTN_W-1:0]     Button,
  input  logic [SW_W-1:0]      Switch
);

  logic             wr;
  logic             chg_clr;
  logic [N_IRQ-1:0] irq_pend;
  logic [N_IRQ-1:0] irq_mask;
  logic [N_IRQ-1:0] src_hist;
  logic [N_IRQ-1:0] irq_set;
  logic [N_IRQ-1:0] irq_w1c;
  logic [BTN_W-1:0] btn_chg;
  logic [BTN_W-1:0] btn_hist;
  logic [15:0]      sw_ext;
  logic [63:0]      bot_ext;
  logic [3:0]       bot_idx;
  logic [7:0]       rd_data;

  // Digits 0..3 sit at 0x06 down to 0x03, digits 4..7 at 0x16 down to 0x13.
  function automatic logic [7:0] dig_addr(input int i);
    return (i < 4) ? 8'(6 - i) : 8'(26 - i);
  endfunction

  assign wr      = pb.WriteStrobe | pb.kWriteStrobe;
  assign chg_clr = pb.ReadStrobe && (pb.PortID == 8'h22);
  // Edge-mode sources are qualified by history; level-mode sources set whenever high.
  assign irq_set = IrqSrc & ~(src_hist & IRQ_EDGE[N_IRQ-1:0]);
  assign irq_w1c = (wr && pb.PortID == 8'h20) ? pb.DataIn[N_IRQ-1:0] : '0;
  assign sw_ext  = 16'(Switch);
  assign bot_ext = 64'(BotRegs);
  assign bot_idx = pb.PortID[3:0] - 4'd10;

  always_comb begin
    rd_data = '0;
    case (pb.PortID)
      8'h00, 8'h10: rd_data = 8'(Button);
      8'h01:        rd_data = sw_ext[7:0];
      8'h11:        rd_data = sw_ext[15:8];
      8'h09:        rd_data = MotCtl;
      8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F:
        if (int'(bot_idx) < N_BOT) rd_data = bot_ext[{bot_idx[2:0], 3'b000} +: 8];
      8'h20:        rd_data = 8'(irq_pend);
      8'h21:        rd_data = 8'(irq_mask);
      8'h22:        rd_data = 8'(btn_chg);
      default:      rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    src_hist <= IrqSrc;
    btn_hist <= Button;
    if (rst) begin
      MotCtl       <= '0;
      Dig          <= '0;
      DP           <= '0;
      LED          <= '0;
      pb.DataOut   <= '0;
      pb.Interrupt <= 1'b0;
      irq_pend     <= '0;
      irq_mask     <= '0;
      btn_chg      <= '0;
    end else begin
      if (wr) begin
        for (int i = 0; i < LED_W; i++)
          if (pb.PortID == ((i < 8) ? 8'h02 : 8'h12)) LED[i] <= pb.DataIn[i % 8];
        for (int i = 0; i < N_DIG; i++) begin
          if (pb.PortID == dig_addr(i)) Dig[5*i +: 5] <= pb.DataIn[4:0];
          if (pb.PortID == ((i < 4) ? 8'h07 : 8'h17)) DP[i] <= pb.DataIn[i % 4];
        end
        if (pb.PortID == 8'h09) MotCtl <= pb.DataIn;
        if (pb.PortID == 8'h21) irq_mask <= pb.DataIn[N_IRQ-1:0];
      end
      irq_pend   <= (irq_pend & ~irq_w1c) | irq_set;
      btn_chg    <= (btn_chg & ~{BTN_W{chg_clr}}) | (Button & ~btn_hist);
      pb.DataOut <= rd_data;
      // Only an ack drops the request; clearing pending or mask leaves it standing.
      if (pb.InterruptAck)           pb.Interrupt <= 1'b0;
      else if (|(irq_pend & irq_mask)) pb.Interrupt <= 1'b1;
    end
  end

endmodule

// File: tb/tb_nexys4_io_if_v2.sv
// Randomised and directed bench for nexys4_io_if_v2 against a behavioural register model.
module tb_nexys4_io_if_v2;
  localparam logic [7:0] EDGE = 8'h05;  // sources 0,2 edge; 1,3 level

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  MotCtl;
  logic [47:0] BotRegs;
  logic [3:0]  IrqSrc;
  logic [39:0] Dig;
  logic [7:0]  DP;
  logic [15:0] LED;
  logic [4:0]  Button;
  logic [15:0] Switch;

  always #5 clk = ~clk;

  nexys4_io_if_v2_if pb();

  nexys4_io_if_v2 #(.IRQ_EDGE(EDGE)) dut (
    .clk(clk), .rst(rst), .pb(pb), .MotCtl(MotCtl), .BotRegs(BotRegs),
    .IrqSrc(IrqSrc), .Dig(Dig), .DP(DP), .LED(LED), .Button(Button), .Switch(Switch)
  );

  int n_checks = 0;
  int n_err = 0;

  int m_led, m_dp, m_mot, m_pend, m_mask, m_chg, m_prev_src, m_prev_btn, m_do, m_int;
  int m_dig [8];

  logic [7:0] addr_tab [0:17] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h06, 8'h07, 8'h09, 8'h0A,
                                  8'h0F, 8'h10, 8'h11, 8'h12, 8'h13, 8'h16, 8'h17, 8'h20,
                                  8'h21, 8'h22};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_read(input int p);
    case (p)
      'h00, 'h10: return int'(Button);
      'h01:       return int'(Switch) & 255;
      'h11:       return (int'(Switch) >> 8) & 255;
      'h09:       return m_mot;
      'h0A, 'h0B, 'h0C, 'h0D, 'h0E, 'h0F: return int'((BotRegs >> (8 * (p - 'h0A))) & 48'hFF);
      'h20:       return m_pend;
      'h21:       return m_mask;
      'h22:       return m_chg;
      default:    return 0;
    endcase
  endfunction

  function automatic logic [39:0] exp_dig();
    logic [39:0] v = '0;
    for (int i = 0; i < 8; i++) v = v | (40'(m_dig[i] & 31) << (5 * i));
    return v;
  endfunction

  task automatic model_edge();
    int p, d, rd, nint, set;
    p  = int'(pb.PortID);
    d  = int'(pb.DataIn);
    rd = model_read(p);
    if (rst) begin
      m_led = 0; m_dp = 0; m_mot = 0; m_pend = 0; m_mask = 0; m_chg = 0; m_do = 0; m_int = 0;
      for (int i = 0; i < 8; i++) m_dig[i] = 0;
      m_prev_src = int'(IrqSrc);
      m_prev_btn = int'(Button);
      return;
    end
    nint = pb.InterruptAck ? 0 : (((m_pend & m_mask) != 0) ? 1 : m_int);
    set = 0;
    for (int i = 0; i < 4; i++)
      if (IrqSrc[i] && (EDGE[i] == 1'b0 || ((m_prev_src >> i) & 1) == 0)) set |= (1 << i);
    if (pb.WriteStrobe || pb.kWriteStrobe) begin
      if (p == 'h02)                  m_led = (m_led & 'hFF00) | d;
      else if (p == 'h12)             m_led = (m_led & 'h00FF) | (d << 8);
      else if (p >= 'h03 && p <= 'h06) m_dig[6 - p] = d & 31;
      else if (p >= 'h13 && p <= 'h16) m_dig[7 - (p - 'h13)] = d & 31;
      else if (p == 'h07)             m_dp = (m_dp & 'hF0) | (d & 15);
      else if (p == 'h17)             m_dp = (m_dp & 'h0F) | ((d & 15) << 4);
      else if (p == 'h09)             m_mot = d;
      else if (p == 'h20)             m_pend = m_pend & ~d;
      else if (p == 'h21)             m_mask = d & 15;
    end
    m_pend = m_pend | set;
    if (pb.ReadStrobe && p == 'h22) m_chg = 0;
    m_chg = m_chg | (int'(Button) & ~m_prev_btn & 31);
    m_prev_src = int'(IrqSrc);
    m_prev_btn = int'(Button);
    m_do  = rd;
    m_int = nint;
  endtask

  task automatic compare_all();
    check("led", LED, 64'(m_led));
    check("dig", Dig, 64'(exp_dig()));
    check("dp", DP, 64'(m_dp));
    check("mot", MotCtl, 64'(m_mot));
    check("dout", pb.DataOut, 64'(m_do));
    check("irq", pb.Interrupt, 64'(m_int));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d, input bit k);
    pb.PortID = a;
    pb.DataIn = d;
    pb.WriteStrobe  = !k;
    pb.kWriteStrobe = k;
    tick();
    pb.WriteStrobe  = 1'b0;
    pb.kWriteStrobe = 1'b0;
  endtask

  task automatic rd_at(input logic [7:0] a);
    pb.PortID = a;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    pb.PortID = '0; pb.DataIn = '0;
    pb.WriteStrobe = 1'b0; pb.kWriteStrobe = 1'b0; pb.ReadStrobe = 1'b0; pb.InterruptAck = 1'b0;
    IrqSrc = 4'b0001; Button = '0; Switch = 16'hBEEF;
    BotRegs = {16'($urandom), 32'($urandom)};
    BotRegs[23:16] = 8'h3C;
    tick();
    rst = 1'b0;
    pb.PortID = 8'h20;
    tick();
    check("rst_led", LED, 0);
    check("rst_dig", Dig, 0);
    check("rst_dp", DP, 0);
    check("rst_mot", MotCtl, 0);
    check("rst_int", pb.Interrupt, 0);
    tick();
    check("rst_no_edge_pend", pb.DataOut, 0);

    wr(8'h13, 8'h1F, 1'b0);
    check("dig7", Dig[39:35], 5'h1F);
    wr(8'h12, 8'hA5, 1'b1);
    check("led_hi_k", LED[15:8], 8'hA5);
    wr(8'h30, 8'h55, 1'b0);
    check("wr_unmapped_led", LED, 16'hA500);
    check("wr_unmapped_dig", Dig, 40'h1F << 35);

    rd_at(8'h0C); check("rd_bot2", pb.DataOut, 8'h3C);
    rd_at(8'h11); check("rd_sw_hi", pb.DataOut, 8'hBE);
    rd_at(8'h40); check("rd_unmapped", pb.DataOut, 8'h00);

    IrqSrc = 4'b0000;
    wr(8'h21, 8'h01, 1'b0);
    IrqSrc = 4'b0001; tick();
    IrqSrc = 4'b0000; pb.PortID = 8'h20; tick();
    check("irq_pend", pb.DataOut, 8'h01);
    check("irq_int", pb.Interrupt, 1);
    pb.InterruptAck = 1'b1; tick();
    check("ack_drop", pb.Interrupt, 0);
    pb.InterruptAck = 1'b0; tick();
    check("ack_reassert", pb.Interrupt, 1);
    pb.InterruptAck = 1'b1; wr(8'h20, 8'h01, 1'b0); pb.InterruptAck = 1'b0;
    pb.PortID = 8'h20; tick();
    check("w1c_pend", pb.DataOut, 8'h00);
    check("w1c_no_reassert", pb.Interrupt, 0);

    wr(8'h21, 8'h00, 1'b0);
    IrqSrc = 4'b0001; tick();
    IrqSrc = 4'b0000; pb.PortID = 8'h20; tick(); tick();
    check("masked_pend", pb.DataOut, 8'h01);
    check("masked_int", pb.Interrupt, 0);
    wr(8'h21, 8'h01, 1'b0); tick();
    check("unmask_int", pb.Interrupt, 1);
    pb.InterruptAck = 1'b1; wr(8'h20, 8'h01, 1'b0); pb.InterruptAck = 1'b0;
    IrqSrc = 4'b0001; wr(8'h20, 8'h01, 1'b0);
    IrqSrc = 4'b0000; pb.PortID = 8'h20; tick();
    check("set_wins_w1c", pb.DataOut, 8'h01);
    IrqSrc = 4'b0010; wr(8'h20, 8'h02, 1'b0);
    IrqSrc = 4'b0000; pb.PortID = 8'h20; tick();
    check("level_pend", pb.DataOut[1], 1'b1);

    Button = 5'b00100; tick();
    pb.PortID = 8'h22; tick();
    check("chg_set", pb.DataOut, 8'h04);
    pb.ReadStrobe = 1'b1; tick();
    check("chg_read", pb.DataOut, 8'h04);
    pb.ReadStrobe = 1'b0; tick();
    check("chg_cleared", pb.DataOut, 8'h00);
    Button = 5'b00000; tick();
    Button = 5'b00100; pb.ReadStrobe = 1'b1; tick();
    pb.ReadStrobe = 1'b0; tick();
    check("chg_set_wins", pb.DataOut, 8'h04);

    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      pb.PortID = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                              : addr_tab[$urandom_range(0, 17)];
      pb.DataIn       = 8'($urandom);
      pb.WriteStrobe  = ($urandom_range(0, 3) == 0);
      pb.kWriteStrobe = ($urandom_range(0, 9) == 0);
      pb.ReadStrobe   = ($urandom_range(0, 4) == 0);
      pb.InterruptAck = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0)  IrqSrc  = 4'($urandom);
      if ($urandom_range(0, 5) == 0)  Button  = 5'($urandom);
      if ($urandom_range(0, 19) == 0) Switch  = 16'($urandom);
      if ($urandom_range(0, 29) == 0) BotRegs = {16'($urandom), 32'($urandom)};
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
